// File: rtl/ips2l_pcie_apb_initiator.sv
// Source-domain APB initiator: one valid/ready command becomes one APB transfer toward the CDC bridge.
// Optional ACCESS-phase timeout is enabled with `define IPS2L_PCIE_APB_INIT_TIMEOUT_EN.
module ips2l_pcie_apb_initiator #(
    parameter int unsigned GAP_CYCLES     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_RDATA      = 32'hFFFF_FFFF
) (
    input  logic        i_src_clk,
    input  logic        i_src_rst_n,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_we,
    input  logic [15:0] i_cmd_addr,
    input  logic [31:0] i_cmd_wdata,
    input  logic [3:0]  i_cmd_strb,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic        o_p_sel,
    output logic        o_p_ce,
    output logic        o_p_we,
    output logic [15:0] o_p_addr,
    output logic [3:0]  o_p_strb,
    output logic [31:0] o_p_wdata,
    input  logic        i_p_rdy,
    input  logic [31:0] i_p_rdata,
    output logic        o_busy
);

    localparam int unsigned GAP_W = 8;
    localparam int unsigned TO_W  = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_ACCESS = 3'd2,
        S_RESP   = 3'd3,
        S_GAP    = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               cmd_ready_d, rsp_valid_d, sel_d, ce_d, we_d, busy_d;
    logic [31:0]        rsp_rdata_d, wdata_d;
    logic [15:0]        addr_d;
    logic [3:0]         strb_d;
    logic               accept_c;
    logic               timeout_c;

    assign accept_c = (state_q == S_IDLE) && o_cmd_ready && i_cmd_valid;

`ifdef IPS2L_PCIE_APB_INIT_TIMEOUT_EN
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic               rsp_err_d;

    assign timeout_c = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
    logic               unused_timeout_cfg;

    assign timeout_c          = 1'b0;
    assign o_rsp_err          = 1'b0;
    assign unused_timeout_cfg = ^{TO_W'(TIMEOUT_CYCLES), ERR_RDATA};
`endif

    // State and registered outputs
    always_ff @(posedge i_src_clk or negedge i_src_rst_n) begin
        if (!i_src_rst_n) begin
            state_q     <= S_IDLE;
            gap_cnt_q   <= '0;
            o_cmd_ready <= 1'b0;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= '0;
            o_p_sel     <= 1'b0;
            o_p_ce      <= 1'b0;
            o_p_we      <= 1'b0;
            o_p_addr    <= '0;
            o_p_strb    <= '0;
            o_p_wdata   <= '0;
            o_busy      <= 1'b0;
`ifdef IPS2L_PCIE_APB_INIT_TIMEOUT_EN
            to_cnt_q    <= '0;
            o_rsp_err   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            gap_cnt_q   <= gap_cnt_d;
            o_cmd_ready <= cmd_ready_d;
            o_rsp_valid <= rsp_valid_d;
            o_rsp_rdata <= rsp_rdata_d;
            o_p_sel     <= sel_d;
            o_p_ce      <= ce_d;
            o_p_we      <= we_d;
            o_p_addr    <= addr_d;
            o_p_strb    <= strb_d;
            o_p_wdata   <= wdata_d;
            o_busy      <= busy_d;
`ifdef IPS2L_PCIE_APB_INIT_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
            o_rsp_err   <= rsp_err_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept_c) state_d = S_SETUP;
            S_SETUP:  state_d = S_ACCESS;
            S_ACCESS: if (i_p_rdy || timeout_c) state_d = S_RESP;
            S_RESP:   if (i_rsp_ready) state_d = S_GAP;
            S_GAP:    if (gap_cnt_q == '0) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; payload holds until the next accept
    always_comb begin
        cmd_ready_d = 1'b0;
        rsp_valid_d = o_rsp_valid;
        rsp_rdata_d = o_rsp_rdata;
        sel_d       = o_p_sel;
        ce_d        = o_p_ce;
        we_d        = o_p_we;
        addr_d      = o_p_addr;
        strb_d      = o_p_strb;
        wdata_d     = o_p_wdata;
        gap_cnt_d   = gap_cnt_q;
        busy_d      = (state_d != S_IDLE);
`ifdef IPS2L_PCIE_APB_INIT_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
        rsp_err_d   = o_rsp_err;
`endif
        case (state_q)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                if (accept_c) begin
                    cmd_ready_d = 1'b0;
                    sel_d       = 1'b1;
                    ce_d        = 1'b0;
                    we_d        = i_cmd_we;
                    addr_d      = i_cmd_addr;
                    strb_d      = i_cmd_strb;
                    wdata_d     = i_cmd_wdata;
                end
            end
            S_SETUP: begin
                ce_d = 1'b1;
`ifdef IPS2L_PCIE_APB_INIT_TIMEOUT_EN
                to_cnt_d = '0;
`endif
            end
            S_ACCESS: begin
`ifdef IPS2L_PCIE_APB_INIT_TIMEOUT_EN
                to_cnt_d = to_cnt_q + TO_W'(1);
`endif
                // A ready pulse coinciding with the timeout still completes normally
                if (i_p_rdy) begin
                    sel_d       = 1'b0;
                    ce_d        = 1'b0;
                    rsp_rdata_d = o_p_we ? 32'd0 : i_p_rdata;
                    rsp_valid_d = 1'b1;
`ifdef IPS2L_PCIE_APB_INIT_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
`endif
                end else if (timeout_c) begin
                    sel_d       = 1'b0;
                    ce_d        = 1'b0;
                    rsp_rdata_d = ERR_RDATA;
                    rsp_valid_d = 1'b1;
`ifdef IPS2L_PCIE_APB_INIT_TIMEOUT_EN
                    rsp_err_d   = 1'b1;
`endif
                end
            end
            S_RESP: begin
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    gap_cnt_d   = GAP_W'(GAP_CYCLES - 1);
                end
            end
            S_GAP: begin
                if (gap_cnt_q == '0) begin
                    cmd_ready_d = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: ;
        endcase
    end

endmodule
